// File: rtl/dynamixel_sync_writer_pkg.sv
// rtl/dynamixel_sync_writer_pkg.sv - shared Dynamixel 2.0 constants and FSM state encoding
//
// Purpose: constants common to the Dynamixel packet writer and receiver blocks.
// Ports: none (package).

package dynamixel_pkg;

   localparam logic [7:0]  DYN_HDR0            = 8'hFF;
   localparam logic [7:0]  DYN_HDR1            = 8'hFF;
   localparam logic [7:0]  DYN_HDR2            = 8'hFD;
   localparam logic [7:0]  DYN_HDR3            = 8'h00;
   localparam logic [7:0]  DYN_BROADCAST_ID    = 8'hFE;
   localparam logic [7:0]  DYN_INST_SYNC_WRITE = 8'h83;
   localparam logic [7:0]  DYN_STUFF_BYTE      = 8'hFD;
   localparam logic [15:0] DYN_CRC_POLY        = 16'h8005;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_HEADER,
      ST_PARAMS,
      ST_CRC,
      ST_DONE
   } dyn_state_e;

endpackage

// File: rtl/dynamixel_sync_writer_if.sv
// rtl/dynamixel_sync_writer_if.sv - byte stream handshake bundle toward the UART transmitter
//
// Purpose: groups the packet byte stream signals.
// Signals: tx_data (stream byte), tx_valid (byte valid), tx_ready (sink accepts).
// Modports: master = packet source, slave = UART sink.

interface dynamixel_sync_writer_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/dynamixel_crc16.sv
// rtl/dynamixel_crc16.sv - combinational byte-wide Dynamixel CRC-16 update
//
// Purpose: one byte step of CRC-16 (poly 0x8005, MSB first, no reflection).
// Ports: crc_i (running CRC), byte_i (next byte), crc_o (updated CRC).

module dynamixel_crc16
   import dynamixel_pkg::*;
(
   input  logic [15:0] crc_i,
   input  logic [7:0]  byte_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_work;

   always_comb begin
      crc_work = crc_i ^ {byte_i, 8'h00};
      for (int b = 0; b < 8; b++) begin
         crc_work = crc_work[15] ? ({crc_work[14:0], 1'b0} ^ DYN_CRC_POLY)
                                 : {crc_work[14:0], 1'b0};
      end
      crc_o = crc_work;
   end

endmodule

// File: rtl/dynamixel_sync_writer.sv
// rtl/dynamixel_sync_writer.sv - Dynamixel 2.0 Sync Write packet generator with byte stuffing
//
// Purpose: on start, latches address/values, pre-scans the stuffable region to
// count stuffing bytes (so LEN is known before the header goes out), then emits
// header, stuffed parameters and CRC-16 on the tx stream.
// Ports: clock, reset_n (sync, active low), start, address, values,
//        busy, done, tx (byte stream master).

module dynamixel_sync_writer
   import dynamixel_pkg::*;
#(
   parameter int SERVO_COUNT = 4,
   parameter int DATA_BYTES  = 4,
   parameter int ID_BASE     = 1
) (
   input  logic                                clock,
   input  logic                                reset_n,
   input  logic                                start,
   input  logic [15:0]                         address,
   input  logic [SERVO_COUNT*DATA_BYTES*8-1:0] values,
   output logic                                busy,
   output logic                                done,
   dynamixel_sync_writer_if.master             tx
);

   localparam int         VW       = SERVO_COUNT*DATA_BYTES*8;
   localparam int         NPARAM   = SERVO_COUNT*(1+DATA_BYTES);
   localparam logic [7:0] LAST_IDX = 8'(5 + NPARAM - 1);
   localparam logic [2:0] LAST_OFF = 3'(DATA_BYTES);

   dyn_state_e     state_q, state_d;
   logic [15:0]    addr_q, addr_d;
   logic [VW-1:0]  vals_q, vals_d;
   // Position in the stuffable region: idx counts original bytes, servo/off
   // track the servo block so the mux needs no division.
   logic [7:0]     idx_q, idx_d;
   logic [5:0]     servo_q, servo_d;
   logic [2:0]     off_q, off_d;
   logic [2:0]     hdr_q, hdr_d;
   // Last two original bytes, used for FF FF FD detection.
   logic [7:0]     h1_q, h1_d, h2_q, h2_d;
   logic           ins_q, ins_d;      // next emitted byte is an inserted FD
   logic           tail_q, tail_d;    // all original bytes consumed
   logic [15:0]    stuff_q, stuff_d;
   logic [15:0]    crc_q, crc_d;

   logic [7:0]     orig_byte, tx_byte;
   logic [15:0]    vsel, len, crc_next;
   logic           tx_vld, xfer, match;
   logic [7:0]     idx_nx;
   logic [5:0]     servo_nx;
   logic [2:0]     off_nx;

   // Original-byte mux shared by SCAN and PARAMS so both see identical bytes.
   always_comb begin
      vsel      = 16'd0;
      orig_byte = 8'h00;
      case (idx_q)
         8'd0: orig_byte = DYN_INST_SYNC_WRITE;
         8'd1: orig_byte = addr_q[7:0];
         8'd2: orig_byte = addr_q[15:8];
         8'd3: orig_byte = 8'(DATA_BYTES);
         8'd4: orig_byte = 8'h00;
         default: begin
            if (off_q == 3'd0) begin
               orig_byte = 8'(ID_BASE) + 8'(servo_q);
            end else begin
               vsel      = 16'(servo_q) * 16'(DATA_BYTES) + 16'(off_q) - 16'd1;
               orig_byte = vals_q[{vsel, 3'b000} +: 8];
            end
         end
      endcase
   end

   assign match = (h2_q == 8'hFF) && (h1_q == 8'hFF) && (orig_byte == DYN_STUFF_BYTE);
   assign len   = 16'(7 + NPARAM) + stuff_q;

   always_comb begin
      idx_nx   = idx_q + 8'd1;
      servo_nx = servo_q;
      off_nx   = off_q;
      if (idx_q >= 8'd5) begin
         if (off_q == LAST_OFF) begin
            off_nx   = 3'd0;
            servo_nx = servo_q + 6'd1;
         end else begin
            off_nx = off_q + 3'd1;
         end
      end
   end

   always_comb begin
      tx_vld  = 1'b0;
      tx_byte = 8'h00;
      case (state_q)
         ST_HEADER: begin
            tx_vld = 1'b1;
            case (hdr_q)
               3'd0:    tx_byte = DYN_HDR0;
               3'd1:    tx_byte = DYN_HDR1;
               3'd2:    tx_byte = DYN_HDR2;
               3'd3:    tx_byte = DYN_HDR3;
               3'd4:    tx_byte = DYN_BROADCAST_ID;
               3'd5:    tx_byte = len[7:0];
               default: tx_byte = len[15:8];
            endcase
         end
         ST_PARAMS: begin
            tx_vld  = 1'b1;
            tx_byte = ins_q ? DYN_STUFF_BYTE : orig_byte;
         end
         ST_CRC: begin
            tx_vld  = 1'b1;
            tx_byte = hdr_q[0] ? crc_q[15:8] : crc_q[7:0];
         end
         default: ;
      endcase
   end

   assign tx.tx_data  = tx_byte;
   assign tx.tx_valid = tx_vld;
   assign xfer        = tx_vld && tx.tx_ready;
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);

   dynamixel_crc16 u_crc (
      .crc_i  (crc_q),
      .byte_i (tx_byte),
      .crc_o  (crc_next)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      vals_d  = vals_q;
      idx_d   = idx_q;
      servo_d = servo_q;
      off_d   = off_q;
      hdr_d   = hdr_q;
      h1_d    = h1_q;
      h2_d    = h2_q;
      ins_d   = ins_q;
      tail_d  = tail_q;
      stuff_d = stuff_q;
      crc_d   = crc_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SCAN;
               addr_d  = address;
               vals_d  = values;
               idx_d   = 8'd0;
               servo_d = 6'd0;
               off_d   = 3'd0;
               hdr_d   = 3'd0;
               h1_d    = 8'h00;
               h2_d    = 8'h00;
               ins_d   = 1'b0;
               tail_d  = 1'b0;
               stuff_d = 16'd0;
               crc_d   = 16'd0;
            end
         end
         ST_SCAN: begin
            if (match) stuff_d = stuff_q + 16'd1;
            h2_d = h1_q;
            h1_d = orig_byte;
            if (idx_q == LAST_IDX) begin
               // Rewind so PARAMS walks the same bytes from the start.
               state_d = ST_HEADER;
               idx_d   = 8'd0;
               servo_d = 6'd0;
               off_d   = 3'd0;
               h1_d    = 8'h00;
               h2_d    = 8'h00;
            end else begin
               idx_d   = idx_nx;
               servo_d = servo_nx;
               off_d   = off_nx;
            end
         end
         ST_HEADER: begin
            if (xfer) begin
               crc_d = crc_next;
               if (hdr_q == 3'd6) begin
                  hdr_d   = 3'd0;
                  state_d = ST_PARAMS;
               end else begin
                  hdr_d = hdr_q + 3'd1;
               end
            end
         end
         ST_PARAMS: begin
            if (xfer) begin
               crc_d = crc_next;
               if (ins_q) begin
                  ins_d = 1'b0;
                  if (tail_q) state_d = ST_CRC;
               end else begin
                  h2_d  = h1_q;
                  h1_d  = orig_byte;
                  ins_d = match;
                  if (idx_q == LAST_IDX) begin
                     tail_d = 1'b1;
                     if (!match) state_d = ST_CRC;
                  end else begin
                     idx_d   = idx_nx;
                     servo_d = servo_nx;
                     off_d   = off_nx;
                  end
               end
            end
         end
         ST_CRC: begin
            if (xfer) begin
               if (hdr_q[0]) begin
                  hdr_d   = 3'd0;
                  state_d = ST_DONE;
               end else begin
                  hdr_d = 3'd1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         addr_q  <= 16'd0;
         vals_q  <= '0;
         idx_q   <= 8'd0;
         servo_q <= 6'd0;
         off_q   <= 3'd0;
         hdr_q   <= 3'd0;
         h1_q    <= 8'h00;
         h2_q    <= 8'h00;
         ins_q   <= 1'b0;
         tail_q  <= 1'b0;
         stuff_q <= 16'd0;
         crc_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         vals_q  <= vals_d;
         idx_q   <= idx_d;
         servo_q <= servo_d;
         off_q   <= off_d;
         hdr_q   <= hdr_d;
         h1_q    <= h1_d;
         h2_q    <= h2_d;
         ins_q   <= ins_d;
         tail_q  <= tail_d;
         stuff_q <= stuff_d;
         crc_q   <= crc_d;
      end
   end

endmodule
